// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the immediate-generation stage.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FmtNone = 3'd0,
    FmtI    = 3'd1,
    FmtS    = 3'd2,
    FmtB    = 3'd3,
    FmtU    = 3'd4,
    FmtJ    = 3'd5,
    FmtZ    = 3'd6,
    FmtRsvd = 3'd7
  } fmt_t;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

endpackage

// File: rtl/imm_gen_if.sv
// Upstream/downstream handshake bundle of the immediate-generation stage.
interface imm_gen_if #(
  parameter int unsigned XLEN = 32
);
  import imm_gen_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  fmt_t            out_fmt;
  logic [XLEN-1:0] out_target;
  logic [XLEN-1:0] out_pc;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_target, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_target, out_pc
  );

endinterface

// File: rtl/imm_decode.sv
// Combinational immediate decoder for all base-ISA formats, sign-extended to XLEN.
// CSR zimm decode is included only when IMM_GEN_ZICSR_EN is defined.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_t            fmt
);

  logic [31:0] raw;
  logic        sext;

  always_comb begin
    fmt = FmtNone;
    unique case (instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = FmtI;
      OPC_OP_IMM_32: begin
        if (XLEN == 64) fmt = FmtI;
      end
      OPC_STORE:            fmt = FmtS;
      OPC_BRANCH:           fmt = FmtB;
      OPC_LUI, OPC_AUIPC:   fmt = FmtU;
      OPC_JAL:              fmt = FmtJ;
`ifdef IMM_GEN_ZICSR_EN
      OPC_SYSTEM: begin
        if (instr[14]) fmt = FmtZ;
      end
`endif
      default:              fmt = FmtNone;
    endcase
  end

  // Build a 32-bit immediate first; only zimm escapes sign extension.
  always_comb begin
    raw  = '0;
    sext = 1'b1;
    case (fmt)
      FmtI: raw = {{20{instr[31]}}, instr[31:20]};
      FmtS: raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FmtB: raw = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      FmtU: raw = {instr[31:12], 12'b0};
      FmtJ: raw = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      FmtZ: begin
        raw  = {27'b0, instr[19:15]};
        sext = 1'b0;
      end
      default: raw = '0;
    endcase
  end

  assign imm = sext ? XLEN'(signed'(raw)) : XLEN'(raw);

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with a two-entry skid buffer on the output.
// Optional CSR zimm decode is enabled by defining IMM_GEN_ZICSR_EN.
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic      clk,
  input logic      rst,
  input logic      flush,
  imm_gen_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_t            fmt;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc;
  } entry_t;

  state_e          state_q, state_d;
  entry_t          out_q, out_d;
  entry_t          skid_q, skid_d;
  entry_t          new_entry;
  logic [XLEN-1:0] dec_imm;
  fmt_t            dec_fmt;
  logic            out_valid;
  logic            skid_valid;
  logic            in_ready;
  logic            accept;
  logic            drain;

  imm_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instr (bus.in_instr),
    .imm   (dec_imm),
    .fmt   (dec_fmt)
  );

  always_comb begin
    new_entry.imm    = dec_imm;
    new_entry.fmt    = dec_fmt;
    new_entry.target = bus.in_pc + dec_imm;
    new_entry.pc     = bus.in_pc;
  end

  assign out_valid  = (state_q != StEmpty);
  assign skid_valid = (state_q == StFull);
  // Reset is treated like a flush so nothing is accepted while it is held.
  assign in_ready   = !skid_valid && !flush && !rst;
  assign accept     = bus.in_valid && in_ready;
  assign drain      = out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StOne;
          out_d   = new_entry;
        end
      end
      StOne: begin
        if (accept && drain) begin
          out_d = new_entry;
        end else if (accept) begin
          state_d = StFull;
          skid_d  = new_entry;
        end else if (drain) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (drain) begin
          state_d = StOne;
          out_d   = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (flush) state_d = StEmpty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_imm    = out_q.imm;
  assign bus.out_fmt    = out_q.fmt;
  assign bus.out_target = out_q.target;
  assign bus.out_pc     = out_q.pc;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances driven in lockstep, directed
// vectors, back-pressure and flush sequences, then random traffic against a queue model.
module tb_imm_gen_stage;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  imm_gen_if #(.XLEN(32)) bus32 ();
  imm_gen_if #(.XLEN(64)) bus64 ();

  imm_gen_stage #(.XLEN(32)) u_dut32 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus32)
  );

  imm_gen_stage #(.XLEN(64)) u_dut64 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus64)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic        cur_valid;
  logic [31:0] cur_instr;
  logic [63:0] cur_pc;
  logic        cur_ready;

  task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc);
    cur_valid = v;  cur_instr = ins;  cur_pc = pc;
    bus32.in_valid = v;  bus32.in_instr = ins;  bus32.in_pc = pc[31:0];
    bus64.in_valid = v;  bus64.in_instr = ins;  bus64.in_pc = pc;
  endtask

  task automatic set_ready(input logic r);
    cur_ready = r;
    bus32.out_ready = r;
    bus64.out_ready = r;
  endtask

  // Reference decoder: arithmetic on the sign-extended instruction word.
  function automatic void ref_dec(input logic [31:0] ins, input bit x64,
                                  output logic [2:0] fmt, output logic [63:0] imm);
    longint s;
    s   = longint'(signed'(ins));
    fmt = 3'd0;
    imm = 64'd0;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: begin fmt = 3'd1; imm = s >>> 20; end
      7'h1b: if (x64) begin fmt = 3'd1; imm = s >>> 20; end
      7'h23: begin fmt = 3'd2; imm = ((s >>> 25) <<< 5) | longint'(ins[11:7]); end
      7'h63: begin
        fmt = 3'd3;
        imm = (ins[31] ? -64'sd4096 : 64'sd0) + longint'(ins[7]) * 2048
            + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
      end
      7'h37, 7'h17: begin fmt = 3'd4; imm = (s >>> 12) <<< 12; end
      7'h6f: begin
        fmt = 3'd5;
        imm = (ins[31] ? -64'sd1048576 : 64'sd0) + longint'(ins[19:12]) * 4096
            + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
      end
`ifdef IMM_GEN_ZICSR_EN
      7'h73: if (ins[14]) begin fmt = 3'd6; imm = longint'(ins[19:15]); end
`endif
      default: ;
    endcase
    if (!x64) imm = {32'h0, imm[31:0]};
  endfunction

  typedef struct {
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [63:0] pc;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  bit   mon_en = 1'b0;

  logic        exp_rdy;
  logic [2:0]  mf;
  logic [63:0] mi;
  exp_t        me;

  // Scoreboard: the model alone decides acceptance, draining and flushing.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_rdy = !rst && !flush && (q64.size() < 2);
      check("in_ready32", 64'(bus32.in_ready), 64'(exp_rdy));
      check("in_ready64", 64'(bus64.in_ready), 64'(exp_rdy));
      check("out_valid32", 64'(bus32.out_valid), 64'(q32.size() != 0));
      check("out_valid64", 64'(bus64.out_valid), 64'(q64.size() != 0));
      if (q32.size() != 0) begin
        check("sb32_fmt", 64'(bus32.out_fmt), 64'(q32[0].fmt));
        check("sb32_imm", 64'(bus32.out_imm), q32[0].imm);
        check("sb32_tgt", 64'(bus32.out_target), q32[0].tgt);
        check("sb32_pc", 64'(bus32.out_pc), q32[0].pc);
      end
      if (q64.size() != 0) begin
        check("sb64_fmt", 64'(bus64.out_fmt), 64'(q64[0].fmt));
        check("sb64_imm", bus64.out_imm, q64[0].imm);
        check("sb64_tgt", bus64.out_target, q64[0].tgt);
        check("sb64_pc", bus64.out_pc, q64[0].pc);
      end
      if (cur_ready && q32.size() != 0) void'(q32.pop_front());
      if (cur_ready && q64.size() != 0) void'(q64.pop_front());
      if (rst || flush) begin
        q32.delete();
        q64.delete();
      end else if (cur_valid && exp_rdy) begin
        ref_dec(cur_instr, 1'b1, mf, mi);
        me.fmt = mf;  me.imm = mi;  me.tgt = cur_pc + mi;  me.pc = cur_pc;
        q64.push_back(me);
        ref_dec(cur_instr, 1'b0, mf, mi);
        me.fmt = mf;  me.imm = mi;
        me.tgt = {32'h0, cur_pc[31:0] + mi[31:0]};
        me.pc  = {32'h0, cur_pc[31:0]};
        q32.push_back(me);
      end
    end
  end

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [2:0]  f32;
    logic [31:0] i32;
    logic [31:0] t32;
    logic [2:0]  f64;
    logic [63:0] i64;
    logic [63:0] t64;
  } vec_t;

  vec_t tv[10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] opcs [12];
    int         mode;

    tv[0] = '{32'hFFF00093, 64'h100, 3'd1, 32'hFFFFFFFF, 32'h000000FF,
              3'd1, 64'hFFFFFFFFFFFFFFFF, 64'hFF};
    tv[1] = '{32'h800002B7, 64'h0, 3'd4, 32'h80000000, 32'h80000000,
              3'd4, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000};
    tv[2] = '{32'hFE000EE3, 64'h0, 3'd3, 32'hFFFFFFFC, 32'hFFFFFFFC,
              3'd3, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC};
`ifdef IMM_GEN_ZICSR_EN
    tv[3] = '{32'h0052D073, 64'h1000, 3'd6, 32'h5, 32'h1005, 3'd6, 64'h5, 64'h1005};
`else
    tv[3] = '{32'h0052D073, 64'h1000, 3'd0, 32'h0, 32'h1000, 3'd0, 64'h0, 64'h1000};
`endif
    tv[4] = '{32'h0010009B, 64'h200, 3'd0, 32'h0, 32'h200, 3'd1, 64'h1, 64'h201};
    tv[5] = '{32'h7E202FA3, 64'h10, 3'd2, 32'h7FF, 32'h80F, 3'd2, 64'h7FF, 64'h80F};
    tv[6] = '{32'hFF9FF06F, 64'h20, 3'd5, 32'hFFFFFFF8, 32'h18,
              3'd5, 64'hFFFFFFFFFFFFFFF8, 64'h18};
    tv[7] = '{32'h00000033, 64'h40, 3'd0, 32'h0, 32'h40, 3'd0, 64'h0, 64'h40};
    tv[8] = '{32'h12345017, 64'h1000, 3'd4, 32'h12345000, 32'h12346000,
              3'd4, 64'h12345000, 64'h12346000};
    tv[9] = '{32'h01000093, 64'hFFFFFFFFFFFFFFF0, 3'd1, 32'h10, 32'h0, 3'd1, 64'h10, 64'h0};

    opcs = '{7'h13, 7'h03, 7'h67, 7'h1b, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h73,
             7'h33, 7'h00};

    // Reset state
    rst = 1'b1;
    flush = 1'b0;
    drive(1'b0, 32'h0, 64'h0);
    set_ready(1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus64.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus64.in_ready), 64'd0);
    check("rst_imm64", bus64.out_imm, 64'd0);
    check("rst_fmt64", 64'(bus64.out_fmt), 64'd0);
    check("rst_tgt64", bus64.out_target, 64'd0);
    check("rst_pc64", bus64.out_pc, 64'd0);
    check("rst_imm32", 64'(bus32.out_imm), 64'd0);
    check("rst_pc32", 64'(bus32.out_pc), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_rel_in_ready", 64'(bus32.in_ready), 64'd1);
    mon_en = 1'b1;

    // Directed vectors, one at a time with out_ready high
    foreach (tv[i]) begin
      @(posedge clk);
      #1 drive(1'b1, tv[i].instr, tv[i].pc);
      @(posedge clk);
      #1 drive(1'b0, 32'h0, 64'h0);
      @(negedge clk);
      check($sformatf("v%0d_valid", i), 64'(bus32.out_valid), 64'd1);
      check($sformatf("v%0d_fmt32", i), 64'(bus32.out_fmt), 64'(tv[i].f32));
      check($sformatf("v%0d_imm32", i), 64'(bus32.out_imm), 64'(tv[i].i32));
      check($sformatf("v%0d_tgt32", i), 64'(bus32.out_target), 64'(tv[i].t32));
      check($sformatf("v%0d_fmt64", i), 64'(bus64.out_fmt), 64'(tv[i].f64));
      check($sformatf("v%0d_imm64", i), bus64.out_imm, tv[i].i64);
      check($sformatf("v%0d_tgt64", i), bus64.out_target, tv[i].t64);
    end
    @(posedge clk);

    // Back-pressure: two accepts fill the buffer, release drains in order
    #1 set_ready(1'b0);
    drive(1'b1, 32'h00100093, 64'h1000);
    @(posedge clk);
    #1 drive(1'b1, 32'h00200093, 64'h2000);
    @(posedge clk);
    #1 drive(1'b1, 32'h00300093, 64'h3000);
    @(negedge clk);
    check("bp_full_ready", 64'(bus64.in_ready), 64'd0);
    check("bp_hold_a", bus64.out_pc, 64'h1000);
    @(posedge clk);
    @(negedge clk);
    check("bp_stall_ready", 64'(bus64.in_ready), 64'd0);
    check("bp_stable_a", bus64.out_pc, 64'h1000);
    @(posedge clk);
    #1 set_ready(1'b1);
    @(negedge clk);
    check("bp_out_a", bus64.out_pc, 64'h1000);
    @(posedge clk);
    @(negedge clk);
    check("bp_out_b", bus64.out_pc, 64'h2000);
    check("bp_out_b_imm", bus64.out_imm, 64'h2);
    @(posedge clk);
    #1 drive(1'b0, 32'h0, 64'h0);
    @(negedge clk);
    check("bp_out_c", bus64.out_pc, 64'h3000);
    check("bp_out_c_valid", 64'(bus32.out_valid), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("bp_empty", 64'(bus32.out_valid), 64'd0);

    // Flush while FULL with an input offered
    @(posedge clk);
    #1 set_ready(1'b0);
    drive(1'b1, 32'h00400093, 64'h4000);
    @(posedge clk);
    #1 drive(1'b1, 32'h00500093, 64'h5000);
    @(posedge clk);
    #1 flush = 1'b1;
    drive(1'b1, 32'h00600093, 64'h6000);
    @(negedge clk);
    check("fl_in_ready", 64'(bus64.in_ready), 64'd0);
    check("fl_valid_during", 64'(bus64.out_valid), 64'd1);
    @(posedge clk);
    #1 flush = 1'b0;
    drive(1'b0, 32'h0, 64'h0);
    @(negedge clk);
    check("fl_valid_after", 64'(bus64.out_valid), 64'd0);
    check("fl_ready_after", 64'(bus64.in_ready), 64'd1);
    @(posedge clk);
    #1 set_ready(1'b1);

    // Random traffic with stalls, flushes and the odd reset
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 99) == 0) mode = $urandom_range(0, 2);
      rst   = ($urandom_range(0, 599) == 0);
      flush = ($urandom_range(0, 59) == 0);
      case (mode)
        0:       set_ready(1'b1);
        1:       set_ready($urandom_range(0, 3) == 0);
        default: set_ready($urandom_range(0, 1) == 1);
      endcase
      begin
        logic [31:0] ins;
        logic [63:0] pc;
        ins = $urandom;
        ins[6:0] = opcs[$urandom_range(0, 11)];
        pc = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1) pc = {32'h0, pc[31:0]};
        drive($urandom_range(0, 3) != 0, ins, pc);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 64'h0);
    set_ready(1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
